// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller for the single-cycle core: decodes RAM, GPIO and a
// down-counter peripheral, and stalls the core through mio_ready on RAM loads.
module mio_bus_ctrl #(
   parameter int RAM_AW      = 10,
   parameter int RAM_LATENCY = 1,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_mio,
   input  logic              mem_w,
   input  logic [31:0]       addr_bus,
   input  logic [31:0]       cpu_data_out,
   output logic [31:0]       cpu_data_in,
   output logic              mio_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       sw_in,
   output logic [7:0]        led_out,
   output logic              cnt_irq
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam int              WAIT_INIT_I = (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;
   localparam logic [1:0]      WAIT_INIT   = WAIT_INIT_I[1:0];
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t            state_q, state_d;
   logic [1:0]        wait_q, wait_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [7:0]        led_q, led_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  reload_q, reload_d;
   logic              en_q, en_d;
   logic              auto_q, auto_d;
   logic              zf_q, zf_d;
   logic              pend_q, pend_d;
   logic              zf_set;

   logic              is_ram, is_gpio, is_cnt, is_ctrl;
   logic              ram_load, wr_ok;
   logic [31:0]       periph_rdata;

   assign is_ram   = (addr_bus[31:28] == 4'h0);
   assign is_gpio  = (addr_bus[31:28] == 4'hE) && (addr_bus[27:0] == 28'h0);
   assign is_cnt   = (addr_bus[31:28] == 4'hF) && (addr_bus[27:0] == 28'h0);
   assign is_ctrl  = (addr_bus[31:28] == 4'hF) && (addr_bus[27:0] == 28'h4);
   assign ram_load = cpu_mio & ~mem_w & is_ram;
   // Writes only land in IDLE; WAIT/DONE always belong to an in-flight load.
   assign wr_ok    = cpu_mio & mem_w & (state_q == IDLE);

   assign ram_addr = addr_bus[RAM_AW+1:2];
   assign ram_din  = cpu_data_out;
   assign ram_we   = wr_ok & is_ram;
   assign led_out  = led_q;
   assign cnt_irq  = zf_q;

   always_comb begin
      periph_rdata = '0;
      if (is_gpio) begin
         periph_rdata = {16'b0, sw_in};
      end else if (is_cnt) begin
         periph_rdata = 32'(count_q);
      end else if (is_ctrl) begin
         periph_rdata = {29'b0, zf_q, auto_q, en_q};
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      rdata_d     = rdata_q;
      mio_ready   = 1'b1;
      cpu_data_in = '0;
      case (state_q)
         IDLE: begin
            if (ram_load) begin
               mio_ready = 1'b0;
               if (RAM_LATENCY > 1) begin
                  state_d = WAIT;
                  wait_d  = WAIT_INIT;
               end else begin
                  state_d = DONE;
                  rdata_d = ram_dout;
               end
            end else if (cpu_mio && !mem_w) begin
               cpu_data_in = periph_rdata;
            end
         end
         WAIT: begin
            mio_ready = 1'b0;
            if (wait_q == 2'd0) begin
               state_d = DONE;
               rdata_d = ram_dout;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         DONE: begin
            // The core advances on this edge, so the held request is not re-accepted.
            cpu_data_in = rdata_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      led_d    = led_q;
      count_d  = count_q;
      reload_d = reload_q;
      en_d     = en_q;
      auto_d   = auto_q;
      zf_d     = zf_q;
      pend_d   = 1'b0;
      zf_set   = 1'b0;
      if (pend_q && (reload_q != '0)) begin
         count_d = reload_q;
      end else if (en_q && (count_q != '0)) begin
         count_d = count_q - CNT_ONE;
         if (count_q == CNT_ONE) begin
            zf_set = 1'b1;
            pend_d = auto_q;
         end
      end
      if (wr_ok && is_gpio) begin
         led_d = cpu_data_out[7:0];
      end
      // A CPU write of COUNT overrides this cycle's decrement or reload entirely.
      if (wr_ok && is_cnt) begin
         count_d  = cpu_data_out[CNT_W-1:0];
         reload_d = cpu_data_out[CNT_W-1:0];
         pend_d   = 1'b0;
         zf_set   = 1'b0;
      end
      if (wr_ok && is_ctrl) begin
         en_d   = cpu_data_out[0];
         auto_d = cpu_data_out[1];
         if (cpu_data_out[2]) begin
            zf_d = 1'b0;
         end
      end
      if (zf_set) begin
         zf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         wait_q   <= 2'd0;
         rdata_q  <= '0;
         led_q    <= '0;
         count_q  <= '0;
         reload_q <= '0;
         en_q     <= 1'b0;
         auto_q   <= 1'b0;
         zf_q     <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         rdata_q  <= rdata_d;
         led_q    <= led_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         en_q     <= en_d;
         auto_q   <= auto_d;
         zf_q     <= zf_d;
         pend_q   <= pend_d;
      end
   end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: two instances (RAM latency 1 and 3) share one bus
// stimulus and are checked against a transaction-level reference model.
module tb_mio_bus_ctrl;

   logic        clk;
   logic        rst;
   logic        req_l1, req_l3;
   logic        mem_w;
   logic [31:0] addr_bus;
   logic [31:0] cpu_data_out;
   logic [15:0] sw_in;

   logic [31:0] cpu_data_in_l1, cpu_data_in_l3;
   logic        mio_ready_l1, mio_ready_l3;
   logic [9:0]  ram_addr_l1, ram_addr_l3;
   logic [31:0] ram_din_l1, ram_din_l3;
   logic        ram_we_l1, ram_we_l3;
   logic [31:0] ram_dout_l1, ram_dout_l3;
   logic [7:0]  led_out_l1, led_out_l3;
   logic        cnt_irq_l1, cnt_irq_l3;

   int n_checks = 0;
   int n_pass   = 0;

   mio_bus_ctrl #(.RAM_AW(10), .RAM_LATENCY(1), .CNT_W(32)) u_l1 (
      .clk(clk), .rst(rst), .cpu_mio(req_l1), .mem_w(mem_w), .addr_bus(addr_bus),
      .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in_l1), .mio_ready(mio_ready_l1),
      .ram_addr(ram_addr_l1), .ram_din(ram_din_l1), .ram_we(ram_we_l1), .ram_dout(ram_dout_l1),
      .sw_in(sw_in), .led_out(led_out_l1), .cnt_irq(cnt_irq_l1)
   );

   mio_bus_ctrl #(.RAM_AW(10), .RAM_LATENCY(3), .CNT_W(32)) u_l3 (
      .clk(clk), .rst(rst), .cpu_mio(req_l3), .mem_w(mem_w), .addr_bus(addr_bus),
      .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in_l3), .mio_ready(mio_ready_l3),
      .ram_addr(ram_addr_l3), .ram_din(ram_din_l3), .ram_we(ram_we_l3), .ram_dout(ram_dout_l3),
      .sw_in(sw_in), .led_out(led_out_l3), .cnt_irq(cnt_irq_l3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM devices: data for an address presented in cycle t is sampled at edge t+LATENCY.
   logic [31:0] mem_l1 [0:1023];
   logic [31:0] mem_l3 [0:1023];
   logic [31:0] pipe3_0, pipe3_1;
   assign ram_dout_l1 = mem_l1[ram_addr_l1];
   assign ram_dout_l3 = pipe3_1;
   always @(posedge clk) begin
      if (ram_we_l1) mem_l1[ram_addr_l1] <= ram_din_l1;
      if (ram_we_l3) mem_l3[ram_addr_l3] <= ram_din_l3;
      pipe3_0 <= mem_l3[ram_addr_l3];
      pipe3_1 <= pipe3_0;
   end

   // Reference model state
   logic [31:0] ref_mem [0:1023];
   bit          written [0:63];
   logic [31:0] m_count, m_reload;
   logic        m_en, m_auto, m_zf, m_pend;
   logic [7:0]  m_led;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      m_count = 0; m_reload = 0; m_en = 0; m_auto = 0; m_zf = 0; m_pend = 0; m_led = 0;
   endtask

   // Advances the peripheral model by one clock edge using the bus inputs of that cycle.
   task automatic model_step();
      bit          wr, set_zf, np;
      logic [31:0] a, d, nc;
      if (!rst) begin
         model_reset();
         return;
      end
      wr = (req_l1 || req_l3) && mem_w;
      a = addr_bus;
      d = cpu_data_out;
      nc = m_count; np = 0; set_zf = 0;
      if (m_pend && m_reload != 0) nc = m_reload;
      else if (m_en && m_count != 0) begin
         nc = m_count - 1;
         if (nc == 0) begin set_zf = 1; np = m_auto; end
      end
      if (wr && a == 32'hE000_0000) m_led = d[7:0];
      if (wr && a == 32'hF000_0000) begin nc = d; m_reload = d; np = 0; set_zf = 0; end
      if (wr && a == 32'hF000_0004) begin
         m_en = d[0]; m_auto = d[1];
         if (d[2]) m_zf = 0;
      end
      if (set_zf) m_zf = 1;
      m_count = nc;
      m_pend = np;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:28] == 4'h0) return ref_mem[a[11:2]];
      if (a == 32'hE000_0000) return {16'b0, sw_in};
      if (a == 32'hF000_0000) return m_count;
      if (a == 32'hF000_0004) return {29'b0, m_zf, m_auto, m_en};
      return 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk_side();
      chk("led_l1", led_out_l1, m_led);
      chk("led_l3", led_out_l3, m_led);
      chk("irq_l1", cnt_irq_l1, m_zf);
      chk("irq_l3", cnt_irq_l3, m_zf);
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      logic exp_we;
      exp_we = (addr[31:28] == 4'h0);
      addr_bus = addr; cpu_data_out = data; mem_w = 1'b1; req_l1 = 1'b1; req_l3 = 1'b1;
      #1;
      chk("wr_ready_l1", mio_ready_l1, 1);
      chk("wr_ready_l3", mio_ready_l3, 1);
      chk("ram_we_l1", ram_we_l1, exp_we);
      chk("ram_we_l3", ram_we_l3, exp_we);
      chk("ram_addr_l1", ram_addr_l1, addr[11:2]);
      if (exp_we) begin
         ref_mem[addr[11:2]] = data;
         if (addr[11:8] == 4'h0) written[addr[7:2]] = 1;
      end
      tick();
      req_l1 = 1'b0; req_l3 = 1'b0; mem_w = 1'b0;
      #1;
      chk("ram_we_off_l3", ram_we_l3, 0);
      chk_side();
      $display("wr  addr=%08h data=%08h led=%02h cnt=%0d irq=%0b", addr, data, m_led, m_count, m_zf);
   endtask

   task automatic bus_read(input logic [31:0] addr);
      logic [31:0] exp;
      int          lat1, lat3;
      bit          done1, done3, is_ram;
      is_ram = (addr[31:28] == 4'h0);
      addr_bus = addr; mem_w = 1'b0; req_l1 = 1'b1; req_l3 = 1'b1;
      done1 = 0; done3 = 0; lat1 = 0; lat3 = 0;
      for (int cyc = 0; cyc < 20 && !(done1 && done3); cyc++) begin
         #1;
         exp = model_read(addr);
         if (!done1) begin
            if (mio_ready_l1) begin chk("rd_data_l1", cpu_data_in_l1, exp); done1 = 1; end
            else lat1++;
         end
         if (!done3) begin
            if (mio_ready_l3) begin chk("rd_data_l3", cpu_data_in_l3, exp); done3 = 1; end
            else begin lat3++; chk("stall_data_l3", cpu_data_in_l3, 0); end
         end
         tick();
         if (done1) req_l1 = 1'b0;
         if (done3) req_l3 = 1'b0;
      end
      chk("rd_done", {30'b0, done1, done3}, 32'd3);
      chk("rd_lat_l1", lat1, is_ram ? 1 : 0);
      chk("rd_lat_l3", lat3, is_ram ? 3 : 0);
      chk_side();
      $display("rd  addr=%08h data=%08h lat=%0d/%0d", addr, exp, lat1, lat3);
   endtask

   task automatic idle_cycle();
      tick();
      chk_side();
      $display("idl cnt=%0d irq=%0b", m_count, m_zf);
   endtask

   initial begin
      logic [31:0] unmapped [0:3];
      int          idx, op;
      unmapped[0] = 32'h5000_0000; unmapped[1] = 32'hE000_0004;
      unmapped[2] = 32'hF000_0008; unmapped[3] = 32'h3000_0010;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      for (int i = 0; i < 64; i++) written[i] = 0;
      model_reset();
      rst = 1'b0; req_l1 = 0; req_l3 = 0; mem_w = 0; addr_bus = 0; cpu_data_out = 0; sw_in = 0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_ready_l1", mio_ready_l1, 1);
      chk("rst_ready_l3", mio_ready_l3, 1);
      chk("rst_data_l1", cpu_data_in_l1, 0);
      chk("rst_led", led_out_l1, 0);
      chk("rst_irq", cnt_irq_l3, 0);

      // RAM store/load, including back-to-back loads of the same word
      bus_write(32'h0000_0010, 32'hDEAD_BEEF);
      bus_read(32'h0000_0010);
      bus_read(32'h0000_0010);
      bus_write(32'h0000_0014, 32'h1234_5678);
      bus_read(32'h0000_0014);

      // GPIO
      bus_write(32'hE000_0000, 32'h0000_01A5);
      chk("led_a5", led_out_l1, 32'hA5);
      sw_in = 16'h8001;
      bus_read(32'hE000_0000);

      // Counter with auto-reload; third access writes W1C on the 1->0 edge
      bus_write(32'hF000_0000, 32'd3);
      bus_write(32'hF000_0004, 32'h3);
      bus_read(32'hF000_0000);
      bus_read(32'hF000_0000);
      bus_write(32'hF000_0004, 32'h7);
      chk("set_wins_irq", cnt_irq_l1, 1);
      for (int i = 0; i < 6; i++) bus_read(32'hF000_0000);
      bus_read(32'hF000_0004);
      bus_write(32'hF000_0004, 32'h7);
      for (int i = 0; i < 3; i++) bus_read(32'hF000_0000);

      // Unmapped
      bus_read(32'h5000_0000);
      bus_write(32'h5000_0000, 32'hFFFF_FFFF);
      bus_read(32'hF000_0008);

      // Reset during a RAM wait on the latency-3 instance
      addr_bus = 32'h0000_0010; mem_w = 1'b0; req_l3 = 1'b1;
      #1;
      tick();
      chk("mid_wait_ready_l3", mio_ready_l3, 0);
      rst = 1'b0; req_l3 = 1'b0;
      #1;
      chk("arst_ready_l3", mio_ready_l3, 1);
      chk("arst_led_l1", led_out_l1, 0);
      chk("arst_led_l3", led_out_l3, 0);
      chk("arst_irq_l3", cnt_irq_l3, 0);
      addr_bus = 32'hF000_0000; req_l1 = 1'b1; req_l3 = 1'b1;
      #1;
      chk("arst_count_l1", cpu_data_in_l1, 0);
      chk("arst_count_l3", cpu_data_in_l3, 0);
      req_l1 = 1'b0; req_l3 = 1'b0;
      model_reset();
      tick();
      tick();
      rst = 1'b1;
      bus_read(32'h0000_0010);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         op = $urandom_range(0, 9);
         idx = $urandom_range(0, 63);
         case (op)
            0: bus_write(32'(idx) << 2, $urandom);
            1, 2: begin
               if (!written[idx]) idx = 4;
               bus_read(32'(idx) << 2);
            end
            3: bus_write(32'hE000_0000, $urandom);
            4: begin sw_in = 16'($urandom); bus_read(32'hE000_0000); end
            5: bus_write(32'hF000_0000, $urandom_range(0, 6));
            6: bus_write(32'hF000_0004, $urandom_range(0, 7));
            7: bus_read(($urandom_range(0, 1) == 1) ? 32'hF000_0004 : 32'hF000_0000);
            8: begin
               if ($urandom_range(0, 1) == 1) bus_write(unmapped[idx % 4], $urandom);
               else bus_read(unmapped[idx % 4]);
            end
            default: idle_cycle();
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
